// File: rtl/mem_req_sequencer.sv
// Serialises host read/write requests into one-cycle memory command strobes and returns read results.
// Optional MEM_SEQ_WR_ACK_EN: writes also produce a response carrying the written data.
module mem_req_sequencer #(
    parameter int Depth      = 4,
    parameter int Data_width = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [Depth-1:0]      req_addr,
    input  logic [Data_width-1:0] req_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_ok,
    output logic [Data_width-1:0] rsp_data,
    output logic [Depth-1:0]      rsp_addr,
    output logic                  mem_en,
    output logic                  mem_wr_en,
    output logic                  mem_rd_en,
    output logic [Depth-1:0]      mem_add,
    output logic [Data_width-1:0] mem_data_in,
    input  logic                  mem_valid_out,
    input  logic [Data_width-1:0] mem_data_out,
    output logic [7:0]            err_cnt
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // valid never waits on ready, and a held response keeps its fields stable.
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  wr_q;
    logic [Depth-1:0]      addr_q;
    logic [Data_width-1:0] data_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        mem_en    = 1'b0;
        mem_wr_en = 1'b0;
        mem_rd_en = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = ISSUE;
            end
            ISSUE: begin
                // The memory's command bits are inverted: wr_en=0/rd_en=1 means write.
                mem_en    = 1'b1;
                mem_wr_en = !wr_q;
                mem_rd_en = wr_q;
                if (wr_q) begin
`ifdef MEM_SEQ_WR_ACK_EN
                    state_nxt = RESP;
`else
                    state_nxt = IDLE;
`endif
                end else begin
                    state_nxt = WAIT_RD;
                end
            end
            WAIT_RD: state_nxt = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            rsp_ok   <= 1'b0;
            rsp_data <= '0;
            rsp_addr <= '0;
            err_cnt  <= 8'd0;
        end else begin
            if (state == IDLE && req_valid) begin
                wr_q   <= req_write;
                addr_q <= req_addr;
                data_q <= req_data;
            end
            if (state == WAIT_RD) begin
                rsp_ok   <= mem_valid_out;
                rsp_data <= mem_data_out;
                rsp_addr <= addr_q;
                if (!mem_valid_out && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end
`ifdef MEM_SEQ_WR_ACK_EN
            if (state == ISSUE && wr_q) begin
                rsp_ok   <= 1'b1;
                rsp_data <= data_q;
                rsp_addr <= addr_q;
            end
`endif
        end
    end

    assign mem_add     = addr_q;
    assign mem_data_in = data_q;

endmodule

// File: tb/tb_mem_req_sequencer.sv
// Directed bench for mem_req_sequencer with a behavioural 16-entry registered memory.
module tb_mem_req_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [3:0]  req_addr = '0;
    logic [31:0] req_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_ok;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_addr;
    logic        mem_en;
    logic        mem_wr_en;
    logic        mem_rd_en;
    logic [3:0]  mem_add;
    logic [31:0] mem_data_in;
    logic        mem_valid_out;
    logic [31:0] mem_data_out;
    logic [7:0]  err_cnt;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int acc_cyc  = 0;
    int wr_cycles = 0;
    int rd_cycles = 0;
    int bad_cmd   = 0;
    int exp_err   = 0;

    logic [32:0] exp_q[$];
    logic [31:0] shadow[16];
    logic        shadow_vld[16];

    mem_req_sequencer dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_ok(rsp_ok),
        .rsp_data(rsp_data), .rsp_addr(rsp_addr),
        .mem_en(mem_en), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
        .mem_add(mem_add), .mem_data_in(mem_data_in),
        .mem_valid_out(mem_valid_out), .mem_data_out(mem_data_out),
        .err_cnt(err_cnt)
    );

    // clock/reset block
    always #5 clk = ~clk;

    always_ff @(posedge clk) cyc <= cyc + 1;

    // Memory stand-in: write {en,wr,rd}=101, read 110, registered read data and valid.
    logic [31:0] mem_arr[16];
    logic        mem_vld[16];
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) begin
                mem_arr[i] <= '0;
                mem_vld[i] <= 1'b0;
            end
            mem_valid_out <= 1'b0;
            mem_data_out  <= '0;
        end else if (mem_en) begin
            if (!mem_wr_en && mem_rd_en) begin
                mem_arr[mem_add] <= mem_data_in;
                mem_vld[mem_add] <= 1'b1;
            end else if (mem_wr_en && !mem_rd_en) begin
                mem_data_out  <= mem_arr[mem_add];
                mem_valid_out <= mem_vld[mem_add];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst && mem_en) begin
            if (!mem_wr_en && mem_rd_en) wr_cycles <= wr_cycles + 1;
            if (mem_wr_en && !mem_rd_en) rd_cycles <= rd_cycles + 1;
            if (mem_wr_en == mem_rd_en)  bad_cmd   <= bad_cmd + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        exp_err = 0;
        for (int i = 0; i < 16; i++) begin
            shadow[i] = '0;
            shadow_vld[i] = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, req_ready, 1);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_ok"}, rsp_ok, 0);
        check({tag, "_rsp_data"}, rsp_data, 0);
        check({tag, "_rsp_addr"}, rsp_addr, 0);
        check({tag, "_mem_cmd"}, {mem_en, mem_wr_en, mem_rd_en}, 3'b000);
        check({tag, "_mem_add"}, mem_add, 0);
        check({tag, "_mem_data_in"}, mem_data_in, 0);
        check({tag, "_err_cnt"}, err_cnt, 0);
    endtask

    // Drives a request and returns just after the accepting rising edge (req_valid left high).
    task automatic send_req(input logic wr, input logic [3:0] a, input logic [31:0] d);
        int n = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_data  = d;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("req_accept", req_ready, 1);
        acc_cyc = cyc;
        @(posedge clk);
    endtask

    task automatic write_req(input logic [3:0] a, input logic [31:0] d);
        send_req(1'b1, a, d);
        @(negedge clk);
        req_valid = 1'b0;
        check("wr_cmd", {mem_en, mem_wr_en, mem_rd_en}, 3'b101);
        check("wr_add", mem_add, a);
        check("wr_data_in", mem_data_in, d);
        check("wr_req_ready_busy", req_ready, 0);
        shadow[a] = d;
        shadow_vld[a] = 1'b1;
        @(negedge clk);
        check("wr_mem_idle", mem_en, 0);
`ifdef MEM_SEQ_WR_ACK_EN
        check("wr_ack_valid", rsp_valid, 1);
        check("wr_ack_ok", rsp_ok, 1);
        check("wr_ack_data", rsp_data, d);
        check("wr_ack_addr", rsp_addr, a);
        check("wr_ack_err_cnt", err_cnt, exp_err);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("wr_ack_done", rsp_valid, 0);
`else
        check("wr_req_ready_back", req_ready, 1);
        check("wr_no_rsp", rsp_valid, 0);
`endif
    endtask

    task automatic read_req(input logic [3:0] a, input int bp_cycles);
        logic [32:0] e;
        logic [31:0] held;
        exp_q.push_back({shadow_vld[a], shadow[a]});
        send_req(1'b0, a, 32'h0);
        @(negedge clk);
        req_valid = 1'b0;
        check("rd_cmd", {mem_en, mem_wr_en, mem_rd_en}, 3'b110);
        check("rd_add", mem_add, a);
        check("rd_rsp_early1", rsp_valid, 0);
        @(negedge clk);
        check("rd_wait_idle", mem_en, 0);
        check("rd_rsp_early2", rsp_valid, 0);
        @(negedge clk);
        check("rd_rsp_valid", rsp_valid, 1);
        e = exp_q.pop_front();
        check("rd_rsp_ok", rsp_ok, e[32]);
        if (e[32]) check("rd_rsp_data", rsp_data, e[31:0]);
        check("rd_rsp_addr", rsp_addr, a);
        if (!e[32] && exp_err < 255) exp_err++;
        check("rd_err_cnt", err_cnt, exp_err);
        held = rsp_data;
        for (int i = 0; i < bp_cycles; i++) begin
            @(negedge clk);
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_rsp_data", rsp_data, held);
            check("bp_rsp_addr", rsp_addr, a);
            check("bp_req_ready", req_ready, 0);
            check("bp_mem_en", mem_en, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rd_rsp_done", rsp_valid, 0);
        check("rd_idle_ready", req_ready, 1);
    endtask

    initial begin
        int wr_base;
        int rd_base;
        int acc1;
        for (int i = 0; i < 16; i++) begin
            shadow[i] = '0;
            shadow_vld[i] = 1'b0;
        end

        apply_reset();
        check_reset_outputs("reset");

        // write then read back one location; exactly one memory cycle of each kind
        wr_base = wr_cycles;
        rd_base = rd_cycles;
        write_req(4'd5, 32'hDEADBEEF);
        read_req(4'd5, 0);
        check("one_wr_cycle", wr_cycles - wr_base, 1);
        check("one_rd_cycle", rd_cycles - rd_base, 1);

        // response held under 10 cycles of backpressure
        read_req(4'd5, 10);

`ifndef MEM_SEQ_WR_ACK_EN
        // back-to-back writes with req_valid held high: one acceptance every 2 cycles
        send_req(1'b1, 4'd15, 32'hA5A5_0F0F);
        acc1 = acc_cyc;
        shadow[15] = 32'hA5A5_0F0F;
        shadow_vld[15] = 1'b1;
        send_req(1'b1, 4'd0, 32'h0123_4567);
        check("b2b_wr_spacing", acc_cyc - acc1, 2);
        shadow[0] = 32'h0123_4567;
        shadow_vld[0] = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
`else
        write_req(4'd15, 32'hA5A5_0F0F);
        write_req(4'd0, 32'h0123_4567);
        write_req(4'd3, 32'h12345678);
        read_req(4'd3, 0);
`endif
        read_req(4'd15, 0);
        read_req(4'd0, 0);

        // reset during ISSUE drops mem_en asynchronously
        send_req(1'b0, 4'd5, 32'h0);
        @(negedge clk);
        req_valid = 1'b0;
        check("pre_rst_mem_en", mem_en, 1);
        #2 rst = 1'b0;
        #1 check("rst_issue_mem_en", mem_en, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // reset during WAIT_RD: everything back to reset values, no response later
        send_req(1'b0, 4'd5, 32'h0);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_wait_rd", {mem_en, rsp_valid, req_ready}, 3'b000);
        #2 rst = 1'b0;
        #1 check_reset_outputs("rst_wait_rd");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        exp_err = 0;
        for (int i = 0; i < 16; i++) begin
            shadow[i] = '0;
            shadow_vld[i] = 1'b0;
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("no_rsp_after_rst", rsp_valid, 0);
        end
        check("err_cnt_after_rst", err_cnt, 0);

        // unwritten address reads report invalid; counter saturates at 255
        read_req(4'd9, 0);
        check("err_first", err_cnt, 1);
        for (int i = 1; i < 255; i++) read_req(4'd9, 0);
        check("err_at_255", err_cnt, 255);
        for (int i = 255; i < 300; i++) read_req(4'd9, 0);
        check("err_held_255", err_cnt, 255);

        check("no_illegal_cmd", bad_cmd, 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
